// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller slice: FSM state encoding
// and the default conversion width / settle time used by the controller,
// the latch/sync top level and the bench.
package sar_pkg;

   localparam int SAR_N      = 8;
   localparam int SAR_SETTLE = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } sar_state_e;

endpackage

// File: rtl/sar_ctrl_if.sv
// Conversion bus between the SAR controller and its environment.
// The controller is the slave: it takes start/cmp and returns the DAC
// code, result and status. With SAR_OVERRUN_EN defined the bus also
// carries the sticky overrun flag.
interface sar_ctrl_if #(
   parameter int N = sar_pkg::SAR_N
);
   logic         start;
   logic         cmp;
   logic [N-1:0] dac;
   logic [N-1:0] result;
   logic         eoc;
   logic         busy;
`ifdef SAR_OVERRUN_EN
   logic         overrun;

   modport master (
      output start, cmp,
      input  dac, result, eoc, busy, overrun
   );

   modport slave (
      input  start, cmp,
      output dac, result, eoc, busy, overrun
   );
`else
   modport master (
      output start, cmp,
      input  dac, result, eoc, busy
   );

   modport slave (
      input  start, cmp,
      output dac, result, eoc, busy
   );
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit into the clk50
// domain. Both flops clear on rst so the output never starts as X.
module sync_2ff (
   input  logic clk50,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the async input through two flops to resolve metastability.
   always_ff @(posedge clk50) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller. A rising edge on start launches a
// conversion: each bit is tried MSB first, held for SETTLE cycles while
// the DAC and comparator settle, then kept or cleared from the
// synchronized comparator. eoc is a level that stays up until the next
// accepted start.
// Optional build macro: SAR_OVERRUN_EN adds a sticky overrun flag set by
// start edges arriving while a conversion is in progress.
module sar_ctrl
   import sar_pkg::*;
#(
   parameter int N      = SAR_N,
   parameter int SETTLE = SAR_SETTLE
) (
   input  logic     clk50,
   input  logic     rst,
   sar_ctrl_if.slave bus
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(SETTLE);

   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(SETTLE - 1);
   localparam logic [N-1:0]  DAC_MSB = {1'b1, {(N-1){1'b0}}};

   sar_state_e    state, state_nxt;
   logic [N-1:0]  dac_q, dac_nxt;
   logic [N-1:0]  result_q, result_nxt;
   logic          eoc_q, eoc_nxt;
   logic          busy_q, busy_nxt;
   logic [IW-1:0] idx_q, idx_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          last_start;
   logic          cmp_s;
   logic          start_edge;
   logic          in_conv;
`ifdef SAR_OVERRUN_EN
   logic          overrun_q, overrun_nxt;
`endif

   sync_2ff u_cmp_sync (
      .clk50 (clk50),
      .rst   (rst),
      .d     (bus.cmp),
      .q     (cmp_s)
   );

   assign start_edge = bus.start & ~last_start;
   assign in_conv    = (state == ST_SETTLE) || (state == ST_DECIDE);

   // Next-state and datapath decisions for the SAR sequence.
   always_comb begin
      state_nxt  = state;
      dac_nxt    = dac_q;
      result_nxt = result_q;
      eoc_nxt    = eoc_q;
      busy_nxt   = busy_q;
      idx_nxt    = idx_q;
      cnt_nxt    = cnt_q;
`ifdef SAR_OVERRUN_EN
      overrun_nxt = overrun_q | (in_conv & start_edge);
`endif
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start_edge) begin
               eoc_nxt   = 1'b0;
               busy_nxt  = 1'b1;
               dac_nxt   = DAC_MSB;
               idx_nxt   = IDX_TOP;
               cnt_nxt   = CNT_TOP;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_nxt = ST_DECIDE;
            end else begin
               cnt_nxt = cnt_q - CW'(1);
            end
         end
         ST_DECIDE: begin
            dac_nxt[idx_q] = cmp_s;
            if (idx_q != '0) begin
               // Keep/clear this bit and put the next lower trial bit up.
               dac_nxt[idx_q - IW'(1)] = 1'b1;
               idx_nxt   = idx_q - IW'(1);
               cnt_nxt   = CNT_TOP;
               state_nxt = ST_SETTLE;
            end else begin
               result_nxt = dac_nxt;
               eoc_nxt    = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Register FSM state, datapath and start-edge history.
   always_ff @(posedge clk50) begin
      if (rst) begin
         state      <= ST_IDLE;
         dac_q      <= '0;
         result_q   <= '0;
         eoc_q      <= 1'b0;
         busy_q     <= 1'b0;
         idx_q      <= IDX_TOP;
         cnt_q      <= '0;
         // Start held high through reset must not look like an edge.
         last_start <= 1'b1;
`ifdef SAR_OVERRUN_EN
         overrun_q  <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         dac_q      <= dac_nxt;
         result_q   <= result_nxt;
         eoc_q      <= eoc_nxt;
         busy_q     <= busy_nxt;
         idx_q      <= idx_nxt;
         cnt_q      <= cnt_nxt;
         last_start <= bus.start;
`ifdef SAR_OVERRUN_EN
         overrun_q  <= overrun_nxt;
`endif
      end
   end

   assign bus.dac    = dac_q;
   assign bus.result = result_q;
   assign bus.eoc    = eoc_q;
   assign bus.busy   = busy_q;
`ifdef SAR_OVERRUN_EN
   assign bus.overrun = overrun_q;
`endif

endmodule
